// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode/state enums and flag bit indices for alu_seq
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic [2:0] pack_flags(input logic c, input logic n, input logic z);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - combinational datapath: one-shot ops plus a single-bit shift step
// Carry outputs exist only when ALU_FLAGS_EN is defined.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] work_i,
  input  logic             left_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] step_o
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry_o,
  output logic             step_bit_o
`endif
);

  // Shift opcodes reaching here have amount 0, so they pass operand A through.
  always_comb begin
    result_o = a_i;
    case (op_i)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_CMP: begin
        result_o = '0;
        if (a_i > b_i)      result_o[1:0] = 2'd1;
        else if (a_i < b_i) result_o[1:0] = 2'd2;
      end
      default: result_o = a_i;
    endcase
  end

  always_comb begin
    if (left_i) step_o = {work_i[WIDTH-2:0], 1'b0};
    else        step_o = {1'b0, work_i[WIDTH-1:1]};
  end

`ifdef ALU_FLAGS_EN
  // A modular sum smaller than an addend means the add wrapped.
  always_comb begin
    carry_o = 1'b0;
    case (op_i)
      OP_ADD:  carry_o = (result_o < a_i);
      OP_SUB:  carry_o = (a_i < b_i);
      default: carry_o = 1'b0;
    endcase
  end

  assign step_bit_o = left_i ? work_i[WIDTH-1] : work_i[0];
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shifter and registered result
// Optional status flags port enabled by ALU_FLAGS_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [SHW-1:0]   cnt_q;
  logic             left_q;
  logic             in_ready_q;
  logic             out_valid_q;

  op_e              op_d;
  logic [SHW-1:0]   amt_d;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] step_d;

  assign op_d  = op_e'(select);
  assign amt_d = in_b[SHW-1:0];

`ifdef ALU_FLAGS_EN
  logic [2:0] flags_q;
  logic       core_carry;
  logic       step_bit;
  logic [2:0] acc_flags_d;
  logic [2:0] step_flags_d;

  assign acc_flags_d  = pack_flags(core_carry, core_result[WIDTH-1], core_result == '0);
  assign step_flags_d = pack_flags(step_bit, step_d[WIDTH-1], step_d == '0);
  assign flags        = flags_q;
`endif

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (in_a),
    .b_i        (in_b),
    .op_i       (op_d),
    .work_i     (work_q),
    .left_i     (left_q),
    .result_o   (core_result),
    .step_o     (step_d)
`ifdef ALU_FLAGS_EN
    ,
    .carry_o    (core_carry),
    .step_bit_o (step_bit)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      alu_out_q   <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_shift(op_d) && (amt_d != '0)) begin
              work_q  <= in_a;
              cnt_q   <= amt_d;
              left_q  <= (op_d == OP_SHL);
              state_q <= EXEC;
            end else begin
              alu_out_q   <= core_result;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
`ifdef ALU_FLAGS_EN
              flags_q     <= acc_flags_d;
`endif
            end
          end
        end
        EXEC: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - 1'b1;
          // The cycle that sees a count of 1 performs the last shift.
          if (cnt_q == SHW'(1)) begin
            alu_out_q   <= step_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef ALU_FLAGS_EN
            flags_q     <= step_flags_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (16- and 32-bit instances)
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_a16, in_b16, alu_out16;
  logic [2:0]  select16;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_a32, in_b32, alu_out32;
  logic [2:0]  select32;

`ifdef ALU_FLAGS_EN
  logic [2:0]  flags16, flags32;
`endif

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) u16 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_a      (in_a16),
    .in_b      (in_b16),
    .select    (select16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .alu_out   (alu_out16)
`ifdef ALU_FLAGS_EN
    ,
    .flags     (flags16)
`endif
  );

  alu_seq #(.WIDTH(32)) u32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_a      (in_a32),
    .in_b      (in_b32),
    .select    (select32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .alu_out   (alu_out32)
`ifdef ALU_FLAGS_EN
    ,
    .flags     (flags32)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
    in_a16     = a;
    in_b16     = b;
    select16   = sel;
    in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    in_a16     = 16'hDEAD;
    in_b16     = 16'hBEEF;
  endtask

  task automatic wait16(output int l);
    l = 1;
    while (out_valid16 !== 1'b1 && l < 40) begin
      step();
      l++;
    end
  endtask

  task automatic flags16_chk(input string tag, input logic [2:0] exp);
`ifdef ALU_FLAGS_EN
    chk(tag, {29'd0, flags16}, {29'd0, exp});
`endif
  endtask

  initial begin
    reset = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; select16 = 3'b000; out_ready16 = 1'b1;
    in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; select32 = 3'b000; out_ready32 = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready16}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid16}, 32'd0);
    chk("rst_alu_out", {16'd0, alu_out16}, 32'd0);
    flags16_chk("rst_flags", 3'b000);
    reset = 1'b0;
    step();

    // add wraps to zero with carry
    op16(16'hFFFF, 16'h0001, 3'b000);
    wait16(lat);
    chk("add_lat", lat, 32'd1);
    chk("add_out", {16'd0, alu_out16}, 32'h0000);
    chk("add_in_ready_busy", {31'd0, in_ready16}, 32'd0);
    flags16_chk("add_flags", 3'b101);
    step();
    chk("add_done_valid", {31'd0, out_valid16}, 32'd0);
    chk("add_done_ready", {31'd0, in_ready16}, 32'd1);

    op16(16'd3, 16'd5, 3'b001);
    wait16(lat);
    chk("sub_out", {16'd0, alu_out16}, 32'hFFFE);
    flags16_chk("sub_flags", 3'b110);
    step();

    op16(16'hF0F0, 16'h3C3C, 3'b010);
    wait16(lat);
    chk("and_out", {16'd0, alu_out16}, 32'h3030);
    step();
    op16(16'hF0F0, 16'h3C3C, 3'b011);
    wait16(lat);
    chk("or_out", {16'd0, alu_out16}, 32'hFCFC);
    flags16_chk("or_flags", 3'b010);
    step();

    op16(16'd5, 16'd3, 3'b111);
    wait16(lat);
    chk("cmp_gt", {16'd0, alu_out16}, 32'd1);
    step();
    op16(16'd3, 16'd5, 3'b111);
    wait16(lat);
    chk("cmp_lt", {16'd0, alu_out16}, 32'd2);
    flags16_chk("cmp_lt_flags", 3'b000);
    step();
    op16(16'd7, 16'd7, 3'b111);
    wait16(lat);
    chk("cmp_eq", {16'd0, alu_out16}, 32'd0);
    flags16_chk("cmp_eq_flags", 3'b001);
    step();

    // shl by 0x13 -> amount 3
    op16(16'h0001, 16'h0013, 3'b101);
    chk("shl_not_early", {31'd0, out_valid16}, 32'd0);
    wait16(lat);
    chk("shl_lat", lat, 32'd4);
    chk("shl_out", {16'd0, alu_out16}, 32'h0008);
    flags16_chk("shl_flags", 3'b000);
    step();

    op16(16'h8001, 16'h0001, 3'b110);
    wait16(lat);
    chk("shr_lat", lat, 32'd2);
    chk("shr_out", {16'd0, alu_out16}, 32'h4000);
    flags16_chk("shr_flags", 3'b100);
    step();

    // amount 16 mod 16 = 0 behaves like a one-cycle op
    op16(16'h1234, 16'h0010, 3'b101);
    wait16(lat);
    chk("shl0_lat", lat, 32'd1);
    chk("shl0_out", {16'd0, alu_out16}, 32'h1234);
    flags16_chk("shl0_flags", 3'b000);
    step();

    // backpressure with ignored requests
    out_ready16 = 1'b0;
    op16(16'h00FF, 16'h0F0F, 3'b100);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out", {16'd0, alu_out16}, 32'h0FF0);
      chk("bp_valid", {31'd0, out_valid16}, 32'd1);
      chk("bp_ready", {31'd0, in_ready16}, 32'd0);
      in_valid16 = (i % 2 == 0);
      in_a16     = 16'h1111;
      in_b16     = 16'h2222;
      select16   = 3'b000;
      step();
    end
    in_valid16  = 1'b0;
    flags16_chk("bp_flags", 3'b000);
    out_ready16 = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, out_valid16}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready16}, 32'd1);
    chk("bp_release_out", {16'd0, alu_out16}, 32'h0FF0);
    step();
    chk("bp_no_stray_accept", {31'd0, out_valid16}, 32'd0);

    // reset during the third EXEC cycle of a 15-bit shift
    op16(16'h0001, 16'h000F, 3'b101);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, in_ready16}, 32'd1);
    chk("mid_rst_valid", {31'd0, out_valid16}, 32'd0);
    chk("mid_rst_out", {16'd0, alu_out16}, 32'd0);
    flags16_chk("mid_rst_flags", 3'b000);
    op16(16'd2, 16'd2, 3'b000);
    wait16(lat);
    chk("post_rst_lat", lat, 32'd1);
    chk("post_rst_add", {16'd0, alu_out16}, 32'd4);
    step();

    // 32-bit instance: 0x25 mod 32 = 5
    in_a32 = 32'h0000_0001; in_b32 = 32'h0000_0025; select32 = 3'b101; in_valid32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    lat = 1;
    while (out_valid32 !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    chk("w32_lat", lat, 32'd6);
    chk("w32_out", alu_out32, 32'h0000_0020);
    step();
    chk("w32_idle", {31'd0, in_ready32}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
